// File: rtl/hid_key_event_sched.sv
// Diffs HID boot reports against the last committed report and sequences ROM lookups into PS/2 make/break events.
// Optional typematic auto-repeat of the newest held key is enabled by defining HID2PS2_TYPEMATIC_EN.
module hid_key_event_sched #(
    parameter int unsigned REPEAT_DELAY = 25000000,
    parameter int unsigned REPEAT_RATE  = 2500000
)
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rpt_valid,
  output logic        rpt_ready,
  input  logic [7:0]  rpt_mod,
  input  logic [47:0] rpt_keys,
  output logic [7:0]  rom_addr,
  input  logic [8:0]  rom_data,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [8:0]  ev_code,
  output logic        ev_make,
  output logic        busy
);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_MOD    = 3'd1;
  localparam logic [2:0] ST_BRK    = 3'd2;
  localparam logic [2:0] ST_MAK    = 3'd3;
  localparam logic [2:0] ST_COMMIT = 3'd4;
`ifdef HID2PS2_TYPEMATIC_EN
  localparam logic [2:0] ST_RPT    = 3'd5;
  // Counter reloads are offset so the repeat handshake lands exactly DELAY/RATE clocks after the previous one.
  localparam logic [31:0] DLY_LD   = 32'(REPEAT_DELAY - 2);
  localparam logic [31:0] RATE_LD  = 32'(REPEAT_RATE - 2);
`endif

  localparam logic [1:0] SB_ADDR = 2'd0;
  localparam logic [1:0] SB_LOOK = 2'd1;
  localparam logic [1:0] SB_CAPT = 2'd2;
  localparam logic [1:0] SB_EMIT = 2'd3;

  logic [2:0]  state_q, state_d;
  logic [1:0]  sub_q, sub_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  old_mod_q, old_mod_d, new_mod_q, new_mod_d;
  logic [47:0] old_keys_q, old_keys_d, new_keys_q, new_keys_d;
  logic [8:0]  ev_code_q, ev_code_d;
  logic        ev_make_q, ev_make_d;

  logic [7:0]  usage_c;
  logic        cand_c, make_c, last_c, go_next;
  logic [2:0]  phase_nx;

`ifdef HID2PS2_TYPEMATIC_EN
  logic        arm_q, arm_d;
  logic [8:0]  rcode_q, rcode_d;
  logic [7:0]  ruse_q, ruse_d;
  logic [31:0] cnt_q, cnt_d;
`endif

  function automatic logic [7:0] slot_of(input logic [47:0] ks, input logic [2:0] n);
    slot_of = 8'h00;
    for (int i = 0; i < 6; i++)
      if (n == 3'(i)) slot_of = ks[i*8 +: 8];
  endfunction

  function automatic logic in_set(input logic [7:0] c, input logic [47:0] ks);
    in_set = 1'b0;
    for (int i = 0; i < 6; i++)
      if (ks[i*8 +: 8] == c) in_set = 1'b1;
  endfunction

  function automatic logic dup_below(input logic [47:0] ks, input logic [2:0] n);
    dup_below = 1'b0;
    for (int i = 0; i < 6; i++)
      if ((3'(i) < n) && (ks[i*8 +: 8] == slot_of(ks, n))) dup_below = 1'b1;
  endfunction

  // Candidate evaluation for the current scan index.
  always_comb begin
    usage_c  = 8'h00;
    cand_c   = 1'b0;
    make_c   = 1'b0;
    last_c   = (idx_q == 3'd5);
    phase_nx = ST_COMMIT;
    case (state_q)
      ST_MOD: begin
        usage_c  = 8'hE0 | {5'd0, idx_q};
        cand_c   = old_mod_q[idx_q] ^ new_mod_q[idx_q];
        make_c   = new_mod_q[idx_q];
        last_c   = (idx_q == 3'd7);
        phase_nx = ST_BRK;
      end
      ST_BRK: begin
        usage_c  = slot_of(old_keys_q, idx_q);
        cand_c   = (usage_c >= 8'h04) && !in_set(usage_c, new_keys_q) && !dup_below(old_keys_q, idx_q);
        phase_nx = ST_MAK;
      end
      ST_MAK: begin
        usage_c  = slot_of(new_keys_q, idx_q);
        cand_c   = (usage_c >= 8'h04) && !in_set(usage_c, old_keys_q) && !dup_below(new_keys_q, idx_q);
        make_c   = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    sub_d      = sub_q;
    idx_d      = idx_q;
    old_mod_d  = old_mod_q;
    old_keys_d = old_keys_q;
    new_mod_d  = new_mod_q;
    new_keys_d = new_keys_q;
    ev_code_d  = ev_code_q;
    ev_make_d  = ev_make_q;
    go_next    = 1'b0;
`ifdef HID2PS2_TYPEMATIC_EN
    arm_d   = arm_q;
    rcode_d = rcode_q;
    ruse_d  = ruse_q;
    cnt_d   = (cnt_q != 32'd0) ? cnt_q - 32'd1 : cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (rpt_valid) begin
`ifdef HID2PS2_TYPEMATIC_EN
          arm_d = 1'b0;
`endif
          // A 0x01 slot marks keyboard rollover; the report is dropped whole.
          if (!in_set(8'h01, rpt_keys)) begin
            new_mod_d  = rpt_mod;
            new_keys_d = rpt_keys;
            state_d    = ST_MOD;
            sub_d      = SB_ADDR;
            idx_d      = 3'd0;
          end
        end
`ifdef HID2PS2_TYPEMATIC_EN
        else if (arm_q && (cnt_q == 32'd0)) begin
          if (in_set(ruse_q, old_keys_q)) begin
            state_d   = ST_RPT;
            sub_d     = SB_EMIT;
            ev_code_d = rcode_q;
            ev_make_d = 1'b1;
          end else begin
            arm_d = 1'b0;
          end
        end
`endif
      end
      ST_COMMIT: begin
        old_mod_d  = new_mod_q;
        old_keys_d = new_keys_q;
        state_d    = ST_IDLE;
      end
`ifdef HID2PS2_TYPEMATIC_EN
      ST_RPT: begin
        if (ev_ready) begin
          state_d = ST_IDLE;
          sub_d   = SB_ADDR;
          cnt_d   = RATE_LD;
        end
      end
`endif
      default: begin
        case (sub_q)
          SB_ADDR: if (cand_c) sub_d = SB_LOOK; else go_next = 1'b1;
          SB_LOOK: sub_d = SB_CAPT;
          SB_CAPT: begin
            if (rom_data == 9'd0) begin
              go_next = 1'b1;
            end else begin
              ev_code_d = rom_data;
              ev_make_d = make_c;
              sub_d     = SB_EMIT;
            end
          end
          default: begin
            if (ev_ready) begin
              go_next = 1'b1;
`ifdef HID2PS2_TYPEMATIC_EN
              if (state_q == ST_MAK) begin
                arm_d   = 1'b1;
                rcode_d = ev_code_q;
                ruse_d  = usage_c;
                cnt_d   = DLY_LD;
              end else if ((state_q == ST_BRK) && (usage_c == ruse_q)) begin
                arm_d = 1'b0;
              end
`endif
            end
          end
        endcase
        if (go_next) begin
          sub_d = SB_ADDR;
          if (last_c) begin
            idx_d   = 3'd0;
            state_d = phase_nx;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      sub_q      <= SB_ADDR;
      idx_q      <= 3'd0;
      old_mod_q  <= 8'h00;
      old_keys_q <= 48'h0;
      new_mod_q  <= 8'h00;
      new_keys_q <= 48'h0;
      ev_code_q  <= 9'h000;
      ev_make_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      sub_q      <= sub_d;
      idx_q      <= idx_d;
      old_mod_q  <= old_mod_d;
      old_keys_q <= old_keys_d;
      new_mod_q  <= new_mod_d;
      new_keys_q <= new_keys_d;
      ev_code_q  <= ev_code_d;
      ev_make_q  <= ev_make_d;
    end
  end

`ifdef HID2PS2_TYPEMATIC_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      arm_q   <= 1'b0;
      rcode_q <= 9'h000;
      ruse_q  <= 8'h00;
      cnt_q   <= 32'd0;
    end else begin
      arm_q   <= arm_d;
      rcode_q <= rcode_d;
      ruse_q  <= ruse_d;
      cnt_q   <= cnt_d;
    end
  end
`endif

  assign rpt_ready = (state_q == ST_IDLE);
  assign busy      = (state_q != ST_IDLE);
  assign ev_valid  = (sub_q == SB_EMIT);
  assign ev_code   = ev_code_q;
  assign ev_make   = ev_make_q;
  assign rom_addr  = usage_c;

endmodule
